// File: rtl/pipe_buf_pkg.sv
// Shared pipeline types: stage tags, buffer defaults and the packed
// payload structs carried between stages.
package pipes;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } stage_t;

    localparam int PIPE_BUF_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
    } decode_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
    } execute_data_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } memory_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } writeback_data_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/pipe_buf.sv
// Elastic stage-boundary buffer: circular store with valid/ready on
// both sides, flush, and a saturating back-pressure counter.
module pipe_buf
    import pipes::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = PIPE_BUF_DEPTH_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_stall;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_wr_nxt;

    // Status comes only from r_cnt, so in_ready never sees out_ready.
    assign in_ready  = (r_cnt != FULL);
    assign out_valid = (r_cnt != '0);
    assign out_data  = r_mem[r_rd];
    assign count     = r_cnt;

    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_rd_nxt = (r_rd == LAST) ? '0 : r_rd + 1'b1;
    assign w_wr_nxt = (r_wr == LAST) ? '0 : r_wr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd <= w_rd_nxt;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Payload is captured only on an accepted, non-flushed push.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_mem[r_wr] <= in_data;
        end
    end

    assign w_stall = out_valid && !out_ready && !flush;

    pipe_sat_counter #(
        .W(CNT_W)
    ) u_stall (
        .clk  (clk),
        .reset(reset),
        .inc  (w_stall),
        .value(stall_cycles)
    );

endmodule

// File: doc/pipe_buf.md
# pipe_buf

Parametrised elastic pipeline buffer placed between any two stages of the core pipeline (fetch→decode, decode→execute, execute→memory, memory→writeback). It carries one stage's payload struct as an opaque vector with a valid/ready handshake and a circular store of DEPTH entries. It supports a pipeline flush and counts back-pressure cycles. It replaces the bare per-stage registers: every stage boundary is an instance of this block.

## Interface
Parameters:
- WIDTH, 64, payload width in bits (≥1); the instantiating stage passes its payload struct width.
- DEPTH, 2, number of entries (1..8).
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  buffer can accept; it equals !full and is registered-derived, with no combinational path from out_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry is valid; it equals !empty.
- out_ready  in  1  downstream accepts the head.
- out_data  out  WIDTH  head entry; it is undefined (don't-care) when out_valid=0.
- flush  in  1  discard all contents, for example on a branch mispredict or J/BEQ redirect.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- stall_cycles  out  CNT_W  number of cycles with out_valid && !out_ready, saturating.

## Operation
- Storage: DEPTH×WIDTH array, head pointer rd_ptr, tail pointer wr_ptr, and occupancy cnt.
- Both pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- A push occurs when in_valid && in_ready. The block writes mem[wr_ptr] and advances wr_ptr.
- A pop occurs when out_valid && out_ready. The block advances rd_ptr.
- Push and pop in the same cycle: cnt is unchanged and both pointers advance.
- Full (cnt==DEPTH): in_ready=0. A pop that cycle does not enable a push; the freed slot is usable next cycle.
- Empty (cnt==0): out_valid=0. A push that cycle is not visible until the next cycle; there is no fall-through.
- Flush is sampled at the clock edge and has priority over push and pop.
  - Next state: cnt=0, rd_ptr=wr_ptr=0, out_valid=0.
  - A push offered in the flush cycle is dropped, even if in_ready was 1 that cycle.
  - A pop in the flush cycle still completes from the downstream's view. The entry was presented and accepted.
- Reset has priority over flush and produces the same state as flush. It also clears stall_cycles.
- stall_cycles increments by 1 in each cycle with out_valid && !out_ready && !flush && !reset. It holds at 2^CNT_W-1 once it reaches that value. Flush does not clear it.
- in_data is held by the upstream stage only until the push handshake. The buffer must not sample in_data in any other cycle.

## Timing
- Minimum latency is 1 cycle: data pushed in cycle N is on out_data with out_valid=1 in cycle N+1.
- Full throughput (one transfer per cycle, sustained) requires DEPTH≥2.
  - DEPTH=1 gives at most one transfer every 2 cycles under continuous flow, because in_ready is !full.
  - This DEPTH=1 rate is required behaviour, not a defect.
- Reset values: out_valid=0, in_ready=1, count=0, stall_cycles=0. out_data is don't-care.
- A reset asserted mid-stream takes effect at the next edge. Contents are lost and in_ready=1 in the following cycle.
- out_valid, in_ready and count are pure functions of registered state.
- out_data is read combinationally from mem[rd_ptr].

## Structure
- Package pipes gains the following:
  - typedef enum stage_t {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK}.
  - Parameter PIPE_BUF_DEPTH_DEFAULT = 2.
  - The stage payload structs fetch_data_t … writeback_data_t, made packed so that $bits() can drive WIDTH.
- Sub-module pipe_sat_counter (parameter W; ports: clk, reset, inc, value) implements stall_cycles. It will be reused by later performance counters.
- Pointer-wrap logic stays inline.

## Test plan
- Reset, then push 0xA, 0xB, 0xC with out_ready=1 and DEPTH=2. Required: out_data is 0xA, 0xB, 0xC on consecutive cycles starting 1 cycle after each push, count ≤1, and stall_cycles=0.
- Hold out_ready=0 and push 3 items with DEPTH=2. Required: in_ready=0 after 2 pushes, the third is held by upstream, count=2, and stall_cycles increments every cycle from the first out_valid.
- Fill the buffer to full, then assert out_ready=1 and in_valid=1 for 1 cycle. Required: only the pop occurs, count=1, and the push is accepted next cycle.
- Hold count=2 and assert flush together with in_valid=1 (data 0x55). Required: next cycle out_valid=0, count=0, in_ready=1, 0x55 never appears, and stall_cycles is unchanged.
- Push 10 items with DEPTH=3 and alternating out_ready. Required: FIFO order is preserved across pointer wrap, with no loss or duplication.
- With CNT_W=4, stall for 20 cycles. Required: stall_cycles holds at 15. Then assert reset mid-stream. Required: all outputs return to their reset values next cycle.
